// File: rtl/uart_tx_param_if.sv
// Ready/valid word channel from the MMIO side into the UART TX FIFO.
interface uart_tx_param_if #(
    parameter int DataWidth = 8
);
    logic [DataWidth-1:0] DataIn;
    logic                 DataInValid;
    logic                 DataInReady;

    modport master (
        output DataIn,
        output DataInValid,
        input  DataInReady
    );

    modport slave (
        input  DataIn,
        input  DataInValid,
        output DataInReady
    );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: word FIFO, optional parity, 1/2 stop bits.
module uart_tx_param #(
    parameter int ClockFreq = 100_000_000,
    parameter int BaudRate  = 115_200,
    parameter int DataWidth = 8,
    parameter int FifoDepth = 4
) (
    input  logic                         Clock,
    input  logic                         Reset,
    uart_tx_param_if.slave               din,
    input  logic [1:0]                   ParityMode,
    input  logic                         TwoStop,
    output logic                         SOut,
    output logic                         Busy,
    output logic [$clog2(FifoDepth):0]   FifoCount
);

    localparam int SymbolEdgeTime = ClockFreq / BaudRate;
    localparam int CntW = $clog2(SymbolEdgeTime);
    localparam int PtrW = $clog2(FifoDepth);
    localparam int BitW = $clog2(DataWidth);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state, nstate;

    logic [DataWidth-1:0] mem [FifoDepth];
    logic [PtrW-1:0]      wptr, rptr;
    logic [PtrW:0]        count;
    logic                 push, pop, fifo_ne;

    logic [CntW-1:0]      cyc;
    logic [BitW-1:0]      bitcnt;
    logic [DataWidth-1:0] shreg;
    logic                 par_q, par_en, two_q;
    logic                 bit_end, data_last, stop_last;

    assign fifo_ne         = (count != '0);
    assign din.DataInReady = (count != (PtrW+1)'(FifoDepth));
    assign push            = din.DataInValid && din.DataInReady;
    assign FifoCount       = count;

    assign bit_end   = (cyc == CntW'(SymbolEdgeTime - 1));
    assign data_last = bit_end && (bitcnt == BitW'(DataWidth - 1));
    assign stop_last = bit_end && (bitcnt == BitW'(two_q));

    // Pop either from idle or on the final stop cycle, so queued frames abut.
    assign pop = fifo_ne &&
                 ((state == S_IDLE) || ((state == S_STOP) && stop_last));

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset && push) mem[wptr] <= din.DataIn;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state  <= S_IDLE;
            cyc    <= '0;
            bitcnt <= '0;
        end else begin
            state <= nstate;
            if (state == S_IDLE || bit_end) cyc <= '0;
            else                            cyc <= cyc + 1'b1;
            if (bit_end)
                bitcnt <= (nstate != state) ? '0 : bitcnt + 1'b1;
        end
    end

    // Framing options are captured with the word so mid-frame changes wait.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            shreg  <= '0;
            par_q  <= 1'b0;
            par_en <= 1'b0;
            two_q  <= 1'b0;
        end else if (pop) begin
            shreg  <= mem[rptr];
            par_q  <= (^mem[rptr]) ^ (ParityMode == 2'b10);
            par_en <= (ParityMode == 2'b01) || (ParityMode == 2'b10);
            two_q  <= TwoStop;
        end else if (state == S_DATA && bit_end) begin
            shreg <= shreg >> 1;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:   if (fifo_ne) nstate = S_START;
            S_START:  if (bit_end) nstate = S_DATA;
            S_DATA:   if (data_last) nstate = par_en ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) nstate = S_STOP;
            S_STOP:   if (stop_last) nstate = fifo_ne ? S_START : S_IDLE;
            default:  nstate = S_IDLE;
        endcase
    end

    always_comb begin
        SOut = 1'b1;
        Busy = 1'b1;
        case (state)
            S_IDLE:   Busy = 1'b0;
            S_START:  SOut = 1'b0;
            S_DATA:   SOut = shreg[0];
            S_PARITY: SOut = par_q;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: line decoder checks frames against queued expectations.
module tb_uart_tx_param;

    localparam int Freq = 1000;
    localparam int Baud = 100;
    localparam int Set  = 10;

    typedef struct {
        logic [15:0] bits;
        int          n;
        logic [8:0]  data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] pm = 2'b00;
    logic       two = 1'b0;
    logic       sout8, busy8, sout5, busy5;
    logic [2:0] cnt8, cnt5;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    exp_t       q8[$];
    exp_t       q5[$];

    uart_tx_param_if #(.DataWidth(8)) bus8();
    uart_tx_param_if #(.DataWidth(5)) bus5();

    uart_tx_param #(
        .ClockFreq(Freq), .BaudRate(Baud), .DataWidth(8), .FifoDepth(4)
    ) dut8 (
        .Clock(clk), .Reset(rst_n), .din(bus8),
        .ParityMode(pm), .TwoStop(two),
        .SOut(sout8), .Busy(busy8), .FifoCount(cnt8)
    );

    uart_tx_param #(
        .ClockFreq(Freq), .BaudRate(Baud), .DataWidth(5), .FifoDepth(4)
    ) dut5 (
        .Clock(clk), .Reset(rst_n), .din(bus5),
        .ParityMode(pm), .TwoStop(two),
        .SOut(sout5), .Busy(busy5), .FifoCount(cnt5)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic line(input int w);
        return (w == 5) ? sout5 : sout8;
    endfunction

    function automatic logic busy(input int w);
        return (w == 5) ? busy5 : busy8;
    endfunction

    function automatic logic rdy(input int w);
        return (w == 5) ? bus5.DataInReady : bus8.DataInReady;
    endfunction

    function automatic exp_t mk(input logic [8:0] d, input int dw,
                                input bit par, input bit ep, input bit ts);
        exp_t e;
        e.bits = '1;
        e.bits[0] = 1'b0;
        for (int i = 0; i < dw; i++) e.bits[1+i] = d[i];
        e.n = 1 + dw;
        if (par) begin
            e.bits[e.n] = ep;
            e.n++;
        end
        e.n += ts ? 2 : 1;
        e.data = d;
        return e;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic monitor(input int w);
        exp_t e;
        int   bad;
        bit   cut;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (w == 5) q5.delete();
                else        q8.delete();
            end else if (line(w) === 1'b0) begin
                if ((w == 5 ? q5.size() : q8.size()) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame dut%0d: start bit seen, required idle", w);
                    repeat (Set - 1) @(negedge clk);
                end else begin
                    if (w == 5) e = q5.pop_front();
                    else        e = q8.pop_front();
                    bad = 0;
                    cut = 0;
                    for (int c = 0; c < e.n * Set; c++) begin
                        if (c > 0) @(negedge clk);
                        if (!rst_n) begin
                            cut = 1;
                            break;
                        end
                        if (line(w) !== e.bits[c/Set] || busy(w) !== 1'b1) bad++;
                    end
                    if (cut) begin
                        if (w == 5) q5.delete();
                        else        q8.delete();
                    end else begin
                        checks++;
                        if (bad != 0) begin
                            errors++;
                            $display("FAIL frame dut%0d data=%h: %0d of %0d cycles wrong, required 0",
                                     w, e.data, bad, e.n * Set);
                        end
                    end
                end
            end
        end
    endtask

    initial monitor(8);
    initial monitor(5);

    task automatic send(input int w, input logic [8:0] d, input bit par,
                        input bit ep, output int acc);
        int t = 0;
        @(negedge clk);
        if (w == 5) begin
            bus5.DataIn = d[4:0];
            bus5.DataInValid = 1'b1;
        end else begin
            bus8.DataIn = d[7:0];
            bus8.DataInValid = 1'b1;
        end
        while (!rdy(w) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            checks++;
            errors++;
            $display("FAIL accept dut%0d: ready low for 2000 cycles, required high", w);
        end else if (w == 5) begin
            q5.push_back(mk(d, 5, par, ep, two));
        end else begin
            q8.push_back(mk(d, 8, par, ep, two));
        end
        @(posedge clk);
        #1;
        bus5.DataInValid = 1'b0;
        bus8.DataInValid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_fall(input int w, output int fall);
        int t = 0;
        while (busy(w) && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 5000) chk("busy_timeout", t, 0);
        fall = cyc;
    endtask

    task automatic frame_test(input string name, input int w, input logic [8:0] d,
                              input bit par, input bit ep, input int want_len);
        int acc, fall;
        send(w, d, par, ep, acc);
        chk({name, "_lat_busy0"}, busy(w), 0);
        @(posedge clk);
        #1;
        chk({name, "_lat_busy1_sout0"}, {busy(w), line(w)}, 2);
        wait_fall(w, fall);
        chk({name, "_len"}, fall - acc - 1, want_len);
    endtask

    initial begin
        logic [7:0] words [5];
        int acc, fall, n, seen, bcnt;

        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h3C;
        words[3] = 8'h80; words[4] = 8'hFE;

        // Pushes presented while in reset must not land in the FIFO.
        bus8.DataIn = 8'hA5;
        bus8.DataInValid = 1'b1;
        bus5.DataIn = 5'h1A;
        bus5.DataInValid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sout", sout8, 1);
        chk("rst_busy", busy8, 0);
        chk("rst_count", cnt8, 0);
        chk("rst_ready", bus8.DataInReady, 1);
        chk("rst_sout5", sout5, 1);
        chk("rst_count5", cnt5, 0);
        rst_n = 1'b1;
        bus8.DataInValid = 1'b0;
        bus5.DataInValid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_busy", busy8, 0);
        chk("idle_count", cnt8, 0);

        frame_test("8n1_55", 8, 9'h055, 0, 0, 100);
        pm = 2'b01;
        frame_test("even_07", 8, 9'h007, 1, 1, 110);
        pm = 2'b10;
        frame_test("odd_07", 8, 9'h007, 1, 0, 110);
        pm = 2'b01;
        two = 1'b1;
        frame_test("even_2stop", 8, 9'h007, 1, 1, 120);
        two = 1'b0;
        pm = 2'b11;
        frame_test("mode11_none", 8, 9'h0C3, 0, 0, 100);
        pm = 2'b00;

        // FIFO fill with valid held high for 9 cycles.
        n = 0;
        seen = 0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 9) begin
                if (bus8.DataInReady) begin
                    seen++;
                    if (n == 0) acc = cyc + 1;
                    if (n < 5) begin
                        bus8.DataIn = words[n];
                        q8.push_back(mk({1'b0, words[n]}, 8, 0, 0, 0));
                        n++;
                    end else begin
                        bus8.DataIn = 8'hEE;
                    end
                end
                bus8.DataInValid = 1'b1;
            end else begin
                bus8.DataInValid = 1'b0;
            end
        end
        chk("fill_accepted", seen, 5);
        chk("fill_count", cnt8, 4);
        chk("fill_ready", bus8.DataInReady, 0);
        wait_fall(8, fall);
        chk("fill_busy_len", fall - acc - 1, 500);

        // Parity enabled mid-frame applies only to the following word.
        pm = 2'b00;
        send(8, 9'h0A5, 0, 0, acc);
        repeat (30) @(posedge clk);
        #1;
        pm = 2'b01;
        send(8, 9'h03C, 1, 0, n);
        wait_fall(8, fall);
        chk("cfg_latch_len", fall - acc - 1, 210);
        pm = 2'b00;

        send(8, 9'h0FF, 0, 0, acc);
        send(8, 9'h012, 0, 0, n);
        send(8, 9'h034, 0, 0, n);
        repeat (30) @(posedge clk);
        #1;
        chk("mid_queued", cnt8, 2);
        @(negedge clk);
        rst_n = 1'b0;
        bus8.DataIn = 8'h99;
        bus8.DataInValid = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_sout", sout8, 1);
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_count", cnt8, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus8.DataInValid = 1'b0;
        bcnt = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (busy8) bcnt++;
        end
        chk("mid_rst_no_stale", bcnt, 0);
        chk("mid_rst_count_after", cnt8, 0);

        frame_test("dw5_1f", 5, 9'h01F, 0, 0, 70);
        pm = 2'b01;
        frame_test("dw5_even_15", 5, 9'h015, 1, 1, 80);
        pm = 2'b00;

        repeat (20) @(posedge clk);
        #1;
        chk("sb8_drained", q8.size(), 0);
        chk("sb5_drained", q5.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter for the board serial link. It replaces the fixed 8N1, single-byte transmitter with a configurable data width, selectable parity, 1 or 2 stop bits, and an internal FIFO so the CPU-side MMIO logic can queue several words without waiting on the line. It sits between the memory-mapped UART registers and the `SOut` pin, with a ready/valid handshake toward the core.

## Interface
- `ClockFreq`, 100_000_000: clock frequency in Hz.
- `BaudRate`, 115_200: line rate in bit/s. `SymbolEdgeTime = ClockFreq / BaudRate` cycles per bit, and it must be ≥ 2. The counter width is `log2(SymbolEdgeTime)` via `util.vh`.
- `DataWidth`, 8: data bits per frame, 5..9.
- `FifoDepth`, 4: FIFO entries, a power of 2, ≥ 2.

Ports:
- `Clock`  in  1  system clock. This is the block's only clock.
- `Reset`  in  1  synchronous, active-low reset. `Reset == 0` at a rising edge resets the block.
- `DataIn`  in  DataWidth  word to transmit, LSB sent first.
- `DataInValid`  in  1  `DataIn` is valid.
- `DataInReady`  out  1  FIFO can accept a word. A transfer occurs when `DataInValid && DataInReady` at a rising edge.
- `ParityMode`  in  2  parity select: 00 none, 01 even, 10 odd, 11 treated as none.
- `TwoStop`  in  1  0 selects 1 stop bit, 1 selects 2 stop bits.
- `SOut`  out  1  serial line, idle high.
- `Busy`  out  1  a frame is in progress.
- `FifoCount`  out  log2(FifoDepth)+1  number of words currently queued, excluding the frame in flight.

## Operation
- **FIFO**
  - Circular buffer with write and read pointers plus an occupancy count.
  - `DataInReady = (FifoCount != FifoDepth)`, decoded from the registered count.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo `FifoDepth`.
- **FSM states**: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when the FIFO is non-empty, pop the head into the shift register, latch `ParityMode` and `TwoStop`, and go to START.
  - START: `SOut = 0` for one bit time, then go to DATA.
  - DATA: shift out `DataWidth` bits LSB-first, one bit time each. Then go to PARITY if the latched mode is even or odd, otherwise go to STOP.
  - PARITY: `SOut` = XOR of the data bits for even parity, inverted XOR for odd parity. Lasts one bit time, then go to STOP.
  - STOP: `SOut = 1` for 1 or 2 bit times, per the latched `TwoStop`.
- **End of frame**
  - At the final stop-bit cycle, if the FIFO is non-empty, pop and go directly to START. There is no idle gap between queued frames.
  - Otherwise go to IDLE.
- **Bit timing**: a cycle counter runs 0..SymbolEdgeTime-1 and resets on each bit boundary. A bit counter tracks data-bit and stop-bit indices.
- **Configuration changes**: `ParityMode` and `TwoStop` changes mid-frame have no effect until the next frame.
- **Frame length**: (1 + DataWidth + P + S) × SymbolEdgeTime cycles, where P ∈ {0,1} is the parity bit and S ∈ {1,2} is the stop-bit count.

## Timing
- **Reset values**: `SOut = 1`, `Busy = 0`, `FifoCount = 0`, `DataInReady = 1`, FSM in IDLE, all counters 0.
- **Reset mid-frame**: the frame is aborted and the FIFO is flushed. `SOut` is 1 from the reset edge. Any push presented in a reset cycle is ignored.
- **Latency**: a word accepted at edge k into an empty FIFO with the FSM in IDLE is popped at edge k+1. `SOut` falls and `Busy` rises after edge k+1.
- **End of `Busy`**: `Busy` deasserts after the last stop-bit cycle if the FIFO is empty.
- **Full FIFO**: with `FifoCount == FifoDepth`, `DataInReady` is 0 and pushes are stalled. A pop at edge j raises `DataInReady` after edge j.
- **Empty FIFO**: pops never underflow. IDLE holds with `SOut = 1`.
- **`DataIn` sampling**: `DataIn` is captured only at the accepting edge and may change afterward.

## Test plan
- **8N1 framing**: SET=10 (ClockFreq 1000, BaudRate 100), DataWidth 8, push 0x55, no parity, 1 stop.
  - `SOut` levels per 10-cycle bit: 0, then 1,0,1,0,1,0,1,0, then 1.
  - `Busy` is high for exactly 100 cycles, starting 1 cycle after acceptance.
- **Parity**: push 0x07 with even parity → parity bit 1; push 0x07 with odd parity → parity bit 0. Each frame is 110 cycles. With `TwoStop = 1` the frame is 120 cycles with two high stop bits.
- **FIFO fill**: FifoDepth 4, `DataInValid` held high from idle.
  - Exactly 5 words are accepted (first one popped immediately), then `DataInReady` = 0 and `FifoCount` = 4.
  - All 5 frames are sent back-to-back with no idle cycles between them, in order.
- **Config latch**: switch `ParityMode` from 00 to 01 mid-frame → current frame has no parity bit; next frame includes one.
- **Reset mid-frame**: assert `Reset` low during DATA with 2 words queued → next cycle `SOut` = 1, `Busy` = 0, `FifoCount` = 0. After release, no stale frame is sent.
- **DataWidth 5**: push 0x1F, no parity → 5 data ones between start and stop; frame is 70 cycles.
